// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point radix-2 DIT FFT sequencer.
package fft_pkg;

  localparam int N_POINTS = 32;
  localparam int LOG2N    = 5;
  localparam int NBFLY    = 16;
  localparam int AW       = $clog2(N_POINTS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [3:0]    tw;
  } bf_addr_t;

  // In-place butterfly addressing for stage s, butterfly j.
  // All intermediate values stay below 32, so 5-bit arithmetic is exact.
  function automatic bf_addr_t bf_addr(input logic [2:0] s, input logic [3:0] j);
    logic [AW-1:0] half;
    logic [AW-1:0] group;
    logic [AW-1:0] pos;
    logic [AW-1:0] a;
    bf_addr_t      r;
    half  = AW'(1) << s;
    group = AW'(j) >> s;
    pos   = AW'(j) & (half - AW'(1));
    a     = (group << (s + 3'd1)) + pos;
    r.a   = a;
    r.b   = a + half;
    r.tw  = 4'(pos << (3'd4 - s));
    return r;
  endfunction

endpackage

// File: rtl/fft_wr_pipe.sv
// Write-back delay line: carries {valid, addr_a, addr_b} BF_LAT cycles so the
// write strobe lines up with the butterfly datapath result.
module fft_wr_pipe
  import fft_pkg::*;
#(
  parameter int BF_LAT = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_vld,
  input  logic [AW-1:0] i_addr_a,
  input  logic [AW-1:0] i_addr_b,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr_a,
  output logic [AW-1:0] o_wr_addr_b,
  output logic          o_empty
);

  logic [BF_LAT-1:0] r_vld;
  logic [AW-1:0]     r_a [BF_LAT];
  logic [AW-1:0]     r_b [BF_LAT];
  logic              w_pend;

  // Shift valid and addresses; flush kills only the valid bits.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_vld & ~i_flush;
      r_a[0]   <= i_addr_a;
      r_b[0]   <= i_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        r_vld[i] <= r_vld[i-1] & ~i_flush;
        r_a[i]   <= r_a[i-1];
        r_b[i]   <= r_b[i-1];
      end
    end
  end

  // Empty means nothing is queued behind the entry at the output, so a
  // write strobe seen together with empty is the last one outstanding.
  always_comb begin
    w_pend = 1'b0;
    for (int i = 0; i < BF_LAT - 1; i++) begin
      w_pend = w_pend | r_vld[i];
    end
  end

  assign o_empty     = ~w_pend;
  assign o_wr_en     = r_vld[BF_LAT-1];
  assign o_wr_addr_a = r_a[BF_LAT-1];
  assign o_wr_addr_b = r_b[BF_LAT-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Stage/butterfly sequencer for the 32-point FFT. One butterfly is issued per
// divided rate tick; each stage drains its write-backs before the next stage
// starts so no read can overtake a pending write.
module fft_seq_ctrl
  import fft_pkg::*;
#(
  parameter int BF_LAT = 2,
  parameter int DIV_W  = 4
) (
  input  logic             clock_in,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] div_sel,
  output logic             busy,
  output logic             done,
  output logic [2:0]       stage,
  output logic [3:0]       bfly,
  output logic             bf_en,
  output logic [AW-1:0]    addr_a,
  output logic [AW-1:0]    addr_b,
  output logic [3:0]       tw_idx,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr_a,
  output logic [AW-1:0]    wr_addr_b
);

  state_t           r_state, w_nxt_state;
  logic [DIV_W-1:0] r_cnt, w_nxt_cnt;
  logic [DIV_W-1:0] r_div_q, w_nxt_div;
  logic [2:0]       r_stage, w_nxt_stage;
  logic [3:0]       r_bfly, w_nxt_bfly;
  logic             r_busy, r_done, r_bf_en;
  bf_addr_t         r_addr;
  bf_addr_t         w_nxt_addr;
  logic             w_nxt_bf_en;
  logic             w_tick;
  logic             w_wr_en;
  logic             w_pipe_empty;
  logic [AW-1:0]    w_wr_addr_a, w_wr_addr_b;

  assign w_tick = (r_state == RUN) && (r_cnt == r_div_q);

  // Next-state, counters and the look-ahead for the registered strobes.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_div   = r_div_q;
    w_nxt_stage = r_stage;
    w_nxt_bfly  = r_bfly;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_nxt_state = RUN;
          w_nxt_cnt   = '0;
          w_nxt_div   = div_sel;
          w_nxt_stage = '0;
          w_nxt_bfly  = '0;
        end
      end
      RUN: begin
        if (abort) begin
          w_nxt_state = IDLE;
        end else if (w_tick) begin
          w_nxt_cnt = '0;
          if (r_bfly == 4'(NBFLY - 1)) begin
            w_nxt_state = DRAIN;
          end else begin
            w_nxt_bfly = r_bfly + 4'd1;
          end
        end else begin
          w_nxt_cnt = r_cnt + DIV_W'(1);
        end
      end
      DRAIN: begin
        if (abort) begin
          w_nxt_state = IDLE;
        end else if (w_wr_en && w_pipe_empty) begin
          if (r_stage == 3'(LOG2N - 1)) begin
            w_nxt_state = DONE;
          end else begin
            w_nxt_state = RUN;
            w_nxt_stage = r_stage + 3'd1;
            w_nxt_bfly  = '0;
            w_nxt_cnt   = '0;
          end
        end
      end
      DONE: begin
        w_nxt_state = IDLE;
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
    w_nxt_bf_en = (w_nxt_state == RUN) && (w_nxt_cnt == w_nxt_div);
    w_nxt_addr  = bf_addr(w_nxt_stage, w_nxt_bfly);
  end

  // State register and registered outputs; addresses hold between strobes.
  always_ff @(posedge clock_in) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div_q <= '0;
      r_stage <= '0;
      r_bfly  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bf_en <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_div_q <= w_nxt_div;
      r_stage <= w_nxt_stage;
      r_bfly  <= w_nxt_bfly;
      r_busy  <= (w_nxt_state == RUN) || (w_nxt_state == DRAIN);
      r_done  <= (w_nxt_state == DONE);
      r_bf_en <= w_nxt_bf_en;
      if (w_nxt_bf_en) begin
        r_addr <= w_nxt_addr;
      end
    end
  end

  fft_wr_pipe #(
    .BF_LAT(BF_LAT)
  ) u_wr_pipe (
    .i_clk      (clock_in),
    .i_rst_n    (rst_n),
    .i_flush    (abort),
    .i_vld      (r_bf_en),
    .i_addr_a   (r_addr.a),
    .i_addr_b   (r_addr.b),
    .o_wr_en    (w_wr_en),
    .o_wr_addr_a(w_wr_addr_a),
    .o_wr_addr_b(w_wr_addr_b),
    .o_empty    (w_pipe_empty)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign stage     = r_stage;
  assign bfly      = r_bfly;
  assign bf_en     = r_bf_en;
  assign addr_a    = r_addr.a;
  assign addr_b    = r_addr.b;
  assign tw_idx    = r_addr.tw;
  assign wr_en     = w_wr_en;
  assign wr_addr_a = w_wr_addr_a;
  assign wr_addr_b = w_wr_addr_b;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: the driver pushes the expected butterfly,
// write-back and done events of each transform; the monitor pops and compares.
module tb_fft_seq_ctrl;

  localparam int L     = 2;
  localparam int DIV_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, start, abort;
  logic [DIV_W-1:0] div_sel;
  logic             busy, done, bf_en, wr_en;
  logic [2:0]       stage;
  logic [3:0]       bfly, tw_idx;
  logic [4:0]       addr_a, addr_b, wr_addr_a, wr_addr_b;

  fft_seq_ctrl #(.BF_LAT(L), .DIV_W(DIV_W)) dut (
    .clock_in (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .div_sel  (div_sel),
    .busy     (busy),
    .done     (done),
    .stage    (stage),
    .bfly     (bfly),
    .bf_en    (bf_en),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .tw_idx   (tw_idx),
    .wr_en    (wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int s;
    int j;
    int a;
    int b;
    int tw;
  } ev_t;

  ev_t q_bf[$];
  ev_t q_wr[$];
  int  q_done[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  busy_from = 1;
  int  busy_to = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: every butterfly, write-back and done of a transform started
  // in cycle t0 with tick period d+1, derived from the stage timing rules.
  task automatic push_run(input int t0, input int d);
    int  p, half, bc;
    ev_t e;
    p = 16 * (d + 1) + L;
    for (int k = 0; k < 5; k++) begin
      half = 1 << k;
      for (int j = 0; j < 16; j++) begin
        bc   = t0 + 1 + k * p + d + j * (d + 1);
        e.s  = k;
        e.j  = j;
        e.a  = (j / half) * 2 * half + (j % half);
        e.b  = e.a + half;
        e.tw = (j % half) * (16 / half);
        e.cyc = bc;
        q_bf.push_back(e);
        e.cyc = bc + L;
        q_wr.push_back(e);
      end
    end
    q_done.push_back(t0 + 5 * p + 1);
    busy_from = t0 + 1;
    busy_to   = t0 + 5 * p;
  endtask

  // Abort or reset in cycle t: nothing expected after t survives.
  task automatic truncate(input int t);
    while (q_bf.size() > 0 && q_bf[$].cyc > t) q_bf.pop_back();
    while (q_wr.size() > 0 && q_wr[$].cyc > t) q_wr.pop_back();
    while (q_done.size() > 0 && q_done[$] > t) q_done.pop_back();
    if (busy_to > t) busy_to = t;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_bf_en"}, bf_en, 0);
    chk({nm, "_wr_en"}, wr_en, 0);
    chk({nm, "_stage_bfly"}, {stage, bfly}, 0);
    chk({nm, "_addr_tw"}, {addr_a, addr_b, tw_idx}, 0);
    chk({nm, "_wr_addr"}, {wr_addr_a, wr_addr_b}, 0);
  endtask

  // One transform: start with period d+1, run n cycles; optional abort,
  // reset, and noise (ignored start pulses, div_sel churn) while busy.
  task automatic run_xfer(input int d, input int ab_at, input int rs_at,
                          input int n, input bit noise);
    int  t0, p;
    bit  killed;
    t0 = cyc;
    p  = 16 * (d + 1) + L;
    killed = 1'b0;
    start   = 1'b1;
    div_sel = DIV_W'(d);
    push_run(t0, d);
    tick();
    start = 1'b0;
    for (int i = 1; i < n; i++) begin
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
      if (noise) div_sel = DIV_W'($urandom);
      if (noise && !killed && i <= 5 * p && $urandom_range(0, 5) == 0) start = 1'b1;
      if (i == ab_at) begin
        abort  = 1'b1;
        killed = 1'b1;
        truncate(cyc);
      end
      if (i == rs_at) begin
        rst_n  = 1'b0;
        killed = 1'b1;
        truncate(cyc);
      end
      if (rs_at > 0 && i == rs_at + 1) begin
        @(negedge clk);
        chk_zero("post_reset");
      end
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
  endtask

  // Monitor: pop and compare whenever the DUT presents an event.
  always @(negedge clk) begin : monitor
    ev_t e;
    int  dc;
    if (mon_en) begin
      while (q_bf.size() > 0 && q_bf[0].cyc < cyc) begin
        e = q_bf.pop_front();
        chk("bf_missing_cycle", -1, e.cyc);
      end
      while (q_wr.size() > 0 && q_wr[0].cyc < cyc) begin
        e = q_wr.pop_front();
        chk("wr_missing_cycle", -1, e.cyc);
      end
      while (q_done.size() > 0 && q_done[0] < cyc) begin
        dc = q_done.pop_front();
        chk("done_missing_cycle", -1, dc);
      end
      if (bf_en) begin
        if (q_bf.size() == 0) chk("bf_unexpected", 1, 0);
        else begin
          e = q_bf.pop_front();
          chk("bf_cycle", cyc, e.cyc);
          chk("bf_stage", stage, e.s);
          chk("bf_bfly", bfly, e.j);
          chk("bf_addr_a", addr_a, e.a);
          chk("bf_addr_b", addr_b, e.b);
          chk("bf_tw", tw_idx, e.tw);
        end
        if (stage == 0 && bfly == 5) chk("anchor_s0j5", {addr_a, addr_b, tw_idx}, {5'd10, 5'd11, 4'd0});
        if (stage == 2 && bfly == 5) chk("anchor_s2j5", {addr_a, addr_b, tw_idx}, {5'd9, 5'd13, 4'd4});
        if (stage == 4 && bfly == 15) chk("anchor_s4j15", {addr_a, addr_b, tw_idx}, {5'd15, 5'd31, 4'd15});
      end
      if (wr_en) begin
        if (q_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e = q_wr.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr_a", wr_addr_a, e.a);
          chk("wr_addr_b", wr_addr_b, e.b);
        end
      end
      if (done) begin
        if (q_done.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          dc = q_done.pop_front();
          chk("done_cycle", cyc, dc);
        end
      end
      chk("busy", busy, (cyc >= busy_from && cyc <= busy_to) ? 1 : 0);
    end
  end

  initial begin : driver
    int d, ab, p;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    div_sel = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    mon_en = 1'b1;
    tick();

    // Baseline run at full rate, with ignored start pulses while busy.
    run_xfer(0, -1, -1, 5 * 18 + 4, 1'b1);
    // Divided rate: butterflies every 4 cycles, div_sel churn ignored.
    run_xfer(3, -1, -1, 5 * 66 + 4, 1'b1);
    // Abort on the second issue of stage 1, restart 25 cycles after start.
    run_xfer(0, 20, -1, 25, 1'b0);
    run_xfer(0, -1, -1, 5 * 18 + 4, 1'b0);
    // Reset pulse while stage 0 is draining.
    run_xfer(0, -1, 17, 22, 1'b0);
    // start and abort together in IDLE: nothing may start.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    repeat (4) tick();

    // Randomized transforms with occasional aborts.
    for (int r = 0; r < 8; r++) begin
      d = $urandom_range(0, 5);
      p = 16 * (d + 1) + L;
      if ($urandom_range(0, 2) == 0) begin
        ab = $urandom_range(1, 5 * p);
        run_xfer(d, ab, -1, ab + 4, 1'b1);
      end else begin
        run_xfer(d, -1, -1, 5 * p + 4, 1'b1);
      end
    end

    repeat (4) tick();
    chk("bf_left", q_bf.size(), 0);
    chk("wr_left", q_wr.size(), 0);
    chk("done_left", q_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
